// File: rtl/adder_pkg.sv
// Shared types and the Kogge-Stone combine for the pipelined prefix adder.
// Pure definitions: no state, no latency, no flow control.
package adder_pkg;

  localparam int MAX_WIDTH = 64;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Group (hi) absorbs the lower group (lo) it sits directly above.
  function automatic gp_t gp_combine(gp_t hi, gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/prefix_cell.sv
// One generate/propagate combine node of the prefix tree.
// Purely combinational: zero latency, no flow control.
module prefix_cell
  import adder_pkg::*;
(
  input  logic [1:0] hi,
  input  logic [1:0] lo,
  output logic [1:0] o
);

  assign o = gp_combine(gp_t'(hi), gp_t'(lo));

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Kogge-Stone add/sub with one register per prefix level; LEVELS+2 cycles in to out.
// Fixed-depth shift with a global enable: a stalled output freezes every stage; in_ready = !stall.
module pipelined_prefix_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LEVELS = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  // Position 0 of every gp vector is the carry-in; bit i of the operands lives at i+1.
  logic             w_stall;
  logic             w_en;
  logic [WIDTH-1:0] w_b;
  logic             w_c0;
  gp_t  [WIDTH:0]   w_gp0;
  gp_t  [WIDTH:0]   w_lvl [1:LEVELS];
  gp_t  [WIDTH:0]   w_fin;
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_unused_p;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;

  gp_t  [WIDTH:0]   r_gp [0:LEVELS];
  logic [WIDTH-1:0] r_p  [0:LEVELS];
  logic [LEVELS:0]  r_vld;
  logic             r_out_vld;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  assign w_stall  = r_out_vld & ~out_ready;
  assign w_en     = ~w_stall;
  assign in_ready = w_en;

  assign w_b  = sub ? ~b : b;
  assign w_c0 = sub | cin;

  always_comb begin
    w_gp0    = '0;
    w_gp0[0] = '{g: w_c0, p: 1'b0};
    for (int i = 0; i < WIDTH; i++) begin
      w_gp0[i+1] = '{g: a[i] & w_b[i], p: a[i] ^ w_b[i]};
    end
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    localparam int D = 1 << (k - 1);
    for (genvar j = 0; j <= WIDTH; j++) begin : g_pos
      if (j >= D) begin : g_cell
        prefix_cell u_cell (
          .hi (r_gp[k-1][j]),
          .lo (r_gp[k-1][j-D]),
          .o  (w_lvl[k][j])
        );
      end else begin : g_pass
        assign w_lvl[k][j] = r_gp[k-1][j];
      end
    end
  end

  // LEVELS levels span WIDTH positions, so only the MSB group misses the
  // carry-in slot; one extra combine closes it for cout.
  assign w_fin = r_gp[LEVELS];

  always_comb begin
    w_carry    = '0;
    w_unused_p = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_carry[i]    = w_fin[i].g;
      w_unused_p[i] = w_fin[i].p;
    end
  end

  assign w_sum  = r_p[LEVELS] ^ w_carry;
  assign w_cout = w_fin[WIDTH].g | (w_fin[WIDTH].p & w_fin[0].g);
  assign w_ovf  = w_cout ^ w_fin[WIDTH-1].g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld     <= '0;
      for (int s = 0; s <= LEVELS; s++) begin
        r_gp[s] <= '0;
        r_p[s]  <= '0;
      end
      r_out_vld <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_zero    <= 1'b0;
    end else if (w_en) begin
      r_vld <= {r_vld[LEVELS-1:0], in_valid};
      if (in_valid) begin
        r_gp[0] <= w_gp0;
        r_p[0]  <= a ^ w_b;
      end
      for (int s = 1; s <= LEVELS; s++) begin
        r_gp[s] <= w_lvl[s];
        r_p[s]  <= r_p[s-1];
      end
      r_out_vld <= r_vld[LEVELS];
      r_sum     <= w_sum;
      r_cout    <= w_cout;
      r_ovf     <= w_ovf;
      r_zero    <= ~|w_sum;
    end
  end

  assign out_valid = r_out_vld;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Scoreboard bench: 16-bit DUT for directed, streaming, stall and reset cases,
// plus 4/8/32/64-bit instances streaming random ops against an arithmetic model.
module tb_pipelined_prefix_adder;

  localparam int W   = 16;
  localparam int LAT = 6;

  logic         clk;
  logic         rst_n;
  logic         rst_aux;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_sent = 0;
  int n_ret  = 0;
  bit chk_lat = 1'b1;

  typedef struct {
    logic [66:0] res;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [66:0] act, input logic [66:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [66:0] pack_res(input logic co, input logic ov, input logic z,
                                           input logic [63:0] s);
    return {co, ov, z, s};
  endfunction

  // Plain integer arithmetic on masked operands; overflow from operand/result signs.
  function automatic logic [66:0] ref_model(input int w, input logic [63:0] ia,
                                            input logic [63:0] ib, input logic ic,
                                            input logic isub);
    logic [63:0] m, am, bm, s;
    logic [64:0] full;
    logic        c0, co, ov;
    m    = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am   = ia & m;
    bm   = (isub ? ~ib : ib) & m;
    c0   = isub | ic;
    full = {1'b0, am} + {1'b0, bm} + {64'd0, c0};
    s    = full[63:0] & m;
    co   = full[w];
    ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
    return {co, ov, (s == 64'd0), s};
  endfunction

  pipelined_prefix_adder #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid && out_ready) begin
      n_ret++;
      if (sb_q.size() == 0) begin
        chk("extra_result", 67'(1), 67'(0));
      end else begin
        mon_e = sb_q.pop_front();
        chk("res", pack_res(cout, ovf, zero, 64'(sum)), mon_e.res);
        if (chk_lat) chk("latency", 67'(cyc - mon_e.acc), 67'(LAT));
      end
    end
  end

  // Call between a rising edge and the following falling edge.
  task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                      input logic isub, input logic [66:0] ex, output int tries);
    bit acc;
    acc      = 1'b0;
    tries    = -1;
    a        = ia;
    b        = ib;
    cin      = ic;
    sub      = isub;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back('{res: ex, acc: cyc});
        n_sent++;
        acc   = 1'b1;
        tries = t;
        break;
      end
    end
    if (!acc) chk("accept_timeout", 67'(0), 67'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [W-1:0] ia, ib;
    logic         ic, isub;
    int           tries;
    ia   = W'($urandom());
    ib   = W'($urandom());
    ic   = 1'($urandom_range(0, 1));
    isub = 1'($urandom_range(0, 1));
    send(ia, ib, ic, isub, ref_model(W, 64'(ia), 64'(ib), ic, isub), tries);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb_q.size() != 0; t++) @(negedge clk);
    @(posedge clk);
    #1;
    chk("drain_empty", 67'(sb_q.size()), 67'(0));
  endtask

  task automatic stall_seq();
    logic [66:0] snap;
    repeat (10) @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("stall_ovld", 67'(out_valid), 67'(1));
    chk("stall_irdy", 67'(in_ready), 67'(0));
    snap = pack_res(cout, ovf, zero, 64'(sum));
    repeat (4) begin
      @(negedge clk);
      chk("stall_irdy", 67'(in_ready), 67'(0));
      chk("stall_hold", pack_res(cout, ovf, zero, 64'(sum)), snap);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_aux
    localparam int AW   = (gi == 0) ? 4 : (gi == 1) ? 8 : (gi == 2) ? 32 : 64;
    localparam int ALAT = $clog2(AW) + 2;

    logic          xv, xr, xo, xro;
    logic [AW-1:0] xa, xb, xs;
    logic          xci, xsb, xco, xof, xz;
    logic [66:0]   xq[$];
    int            xacc[$];
    int            xret;
    bit            xdone;

    pipelined_prefix_adder #(.WIDTH(AW)) u_dut (
      .clk       (clk),
      .rst_n     (rst_aux),
      .in_valid  (xv),
      .in_ready  (xr),
      .a         (xa),
      .b         (xb),
      .cin       (xci),
      .sub       (xsb),
      .out_valid (xo),
      .out_ready (xro),
      .sum       (xs),
      .cout      (xco),
      .ovf       (xof),
      .zero      (xz)
    );

    initial begin
      logic [63:0] ra, rb;
      xdone = 1'b0;
      xret  = 0;
      xv    = 1'b0;
      xa    = '0;
      xb    = '0;
      xci   = 1'b0;
      xsb   = 1'b0;
      xro   = 1'b1;
      wait (rst_aux === 1'b1);
      @(posedge clk);
      #1;
      for (int n = 0; n < 20; n++) begin
        ra  = {$urandom(), $urandom()};
        rb  = {$urandom(), $urandom()};
        xa  = ra[AW-1:0];
        xb  = rb[AW-1:0];
        xci = 1'($urandom_range(0, 1));
        xsb = 1'($urandom_range(0, 1));
        xv  = 1'b1;
        @(negedge clk);
        chk($sformatf("w%0d_irdy", AW), 67'(xr), 67'(1));
        xq.push_back(ref_model(AW, 64'(xa), 64'(xb), xci, xsb));
        xacc.push_back(cyc);
        @(posedge clk);
        #1;
      end
      xv = 1'b0;
      for (int t = 0; t < 40 && xq.size() != 0; t++) @(negedge clk);
      chk($sformatf("w%0d_count", AW), 67'(xret), 67'(20));
      xdone = 1'b1;
    end

    always @(negedge clk) begin
      if (rst_aux === 1'b1 && xo) begin
        xret++;
        if (xq.size() == 0) begin
          chk($sformatf("w%0d_extra", AW), 67'(1), 67'(0));
        end else begin
          chk($sformatf("w%0d_res", AW), pack_res(xco, xof, xz, 64'(xs)), xq.pop_front());
          chk($sformatf("w%0d_lat", AW), 67'(cyc - xacc.pop_front()), 67'(ALAT));
        end
      end
    end
  end

  initial begin
    int tries;
    int nv;
    bit all_done;
    rst_n     = 1'b1;
    rst_aux   = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    #3;
    rst_n = 1'b0;
    #4;
    chk("rst_outputs", 67'({out_valid, cout, ovf, zero, sum}), 67'(0));
    chk("rst_irdy", 67'(in_ready), 67'(1));
    repeat (3) @(posedge clk);
    #2;
    rst_n   = 1'b1;
    rst_aux = 1'b1;

    // Directed vectors, streamed back to back.
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, pack_res(1'b0, 1'b0, 1'b0, 64'h0100), tries);
    chk("first_accept", 67'(tries), 67'(0));
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, pack_res(1'b1, 1'b0, 1'b1, 64'h0000), tries);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, pack_res(1'b0, 1'b1, 1'b0, 64'h8000), tries);
    send(16'h0005, 16'h0007, 1'b0, 1'b1, pack_res(1'b0, 1'b0, 1'b0, 64'hFFFE), tries);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, pack_res(1'b1, 1'b1, 1'b0, 64'h7FFF), tries);
    drain();

    for (int n = 0; n < 20; n++) send_rand();
    drain();
    chk("stream_count", 67'(n_ret), 67'(n_sent));

    chk_lat = 1'b0;
    fork
      begin
        for (int n = 0; n < 30; n++) send_rand();
      end
      stall_seq();
    join
    drain();
    chk("bp_count", 67'(n_ret), 67'(n_sent));
    chk_lat = 1'b1;

    // Park a result at the output, then reset with three ops in flight.
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) send_rand();
    repeat (8) @(posedge clk);
    #1;
    chk("pre_rst_ovld", 67'(out_valid), 67'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_outputs", 67'({out_valid, cout, ovf, zero, sum}), 67'(0));
    chk("arst_irdy", 67'(in_ready), 67'(1));
    out_ready = 1'b1;
    sb_q.delete();
    #1;
    rst_n = 1'b1;
    send(16'h1234, 16'h0FF0, 1'b1, 1'b0, pack_res(1'b0, 1'b0, 1'b0, 64'h2225), tries);
    chk("post_rst_accept", 67'(tries), 67'(0));
    nv = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    chk("post_rst_nresults", 67'(nv), 67'(1));
    drain();

    all_done = 1'b0;
    for (int t = 0; t < 500 && !all_done; t++) begin
      @(posedge clk);
      all_done = g_aux[0].xdone && g_aux[1].xdone && g_aux[2].xdone && g_aux[3].xdone;
    end
    chk("aux_done", 67'(all_done), 67'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
